iomem_arbiter: RTL and testbench

Two-master arbiter for the SoC's `iomem` peripheral bus. It shares one downstream `iomem` port (GPIO, audio, OLED/VGA, I2C decode) between the PicoRV32 core (master 0) and a second bus master (master 1, e.g. a sprite/audio DMA engine). It uses round-robin arbitration, registers every downstream request, and holds the grant until the slave completes. An optional watchdog terminates transactions to unresponsive addresses.

---
 rtl/iomem_arb_pkg.sv | 14 +
 rtl/iomem_rr_pick.sv | 22 ++
 rtl/iomem_arbiter.sv | 155 +++++++++++++++
 tb/tb_iomem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iomem_arb_pkg.sv
// Shared types and constants for the two-master iomem arbiter.
// State encoding, default error read data and master index width.
package iomem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hFFFF_FFFF;
  localparam int          MIDX_W        = 1;

endpackage

// File: rtl/iomem_rr_pick.sv
// Two-way round-robin selector: on a tie the master
// not granted last wins.
module iomem_rr_pick
  import iomem_arb_pkg::*;
(
  input  logic [1:0]        req,
  input  logic              last,
  output logic              gnt_valid,
  output logic [MIDX_W-1:0] gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = '0;
    unique case (1'b1)
      (req == 2'b11): gnt_idx = MIDX_W'(~last);
      (req == 2'b10): gnt_idx = MIDX_W'(1'b1);
      default:        gnt_idx = '0;
    endcase
  end

endmodule

// File: rtl/iomem_arbiter.sv
// Round-robin arbiter sharing the iomem bus between two masters.
// Define IOMEM_ARB_TIMEOUT_EN to add the busy-state watchdog.
module iomem_arbiter
  import iomem_arb_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEF
) (
  input  logic        CLK,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  input  logic        err_clr,
  output logic        timeout_err
);

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic              last_q;
  logic [MIDX_W-1:0] grant_q;
  logic              gnt_valid;
  logic [MIDX_W-1:0] gnt_idx;
  logic              load;
  logic              fin;
  logic              tmo;
  logic [31:0]       rsp;

  iomem_rr_pick u_pick (
    .req       ({m1_valid, m0_valid}),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) state_q <= ARB_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (gnt_valid) begin
          load    = 1'b1;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (s_ready || tmo) begin
          fin     = 1'b1;
          state_d = ARB_DONE;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // A real slave answer always beats the watchdog.
  assign rsp = s_ready ? s_rdata : ERR_RDATA;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      s_valid  <= 1'b0;
      s_wstrb  <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      grant_q  <= '0;
      last_q   <= 1'b1;
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      if (load) begin
        s_valid <= 1'b1;
        grant_q <= gnt_idx;
        if (gnt_idx == MIDX_W'(1'b1)) begin
          s_wstrb <= m1_wstrb;
          s_addr  <= m1_addr;
          s_wdata <= m1_wdata;
        end else begin
          s_wstrb <= m0_wstrb;
          s_addr  <= m0_addr;
          s_wdata <= m0_wdata;
        end
      end
      if (fin) begin
        s_valid <= 1'b0;
        last_q  <= grant_q[0];
        if (grant_q == MIDX_W'(1'b1)) begin
          m1_ready <= 1'b1;
          m1_rdata <= rsp;
        end else begin
          m0_ready <= 1'b1;
          m0_rdata <= rsp;
        end
      end
    end
  end

`ifdef IOMEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] wd_q;

  assign tmo = (state_q == ARB_BUSY) &&
               (wd_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      wd_q        <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (load) begin
        wd_q <= '0;
      end else if (state_q == ARB_BUSY && !s_ready && !tmo) begin
        wd_q <= wd_q + CW'(1);
      end
      if (fin && !s_ready) timeout_err <= 1'b1;
      else if (err_clr)    timeout_err <= 1'b0;
    end
  end
`else
  logic unused_cfg;

  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_cfg  = err_clr ^ (TIMEOUT_CYCLES < 2);
`endif

endmodule

// File: tb/tb_iomem_arbiter.sv
// Directed scoreboard bench for iomem_arbiter.
// Watchdog checks are built only with IOMEM_ARB_TIMEOUT_EN.
module tb_iomem_arbiter;

  logic        CLK = 1'b0;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        err_clr;
  logic        timeout_err;

  iomem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .m0_valid    (m0_valid),
    .m0_wstrb    (m0_wstrb),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_ready    (m0_ready),
    .m0_rdata    (m0_rdata),
    .m1_valid    (m1_valid),
    .m1_wstrb    (m1_wstrb),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_ready    (m1_ready),
    .m1_rdata    (m1_rdata),
    .s_valid     (s_valid),
    .s_wstrb     (s_wstrb),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_ready     (s_ready),
    .s_rdata     (s_rdata),
    .err_clr     (err_clr),
    .timeout_err (timeout_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];
  int   nasrt = 0;
  int   nfail = 0;
  int   cyc_n = 0;
  int   c0;
  bit   slv_en = 0;
  int   slv_lat = 1;
  int   sv_age = 0;
  int   m0_left = 0;
  int   m1_left = 0;
  int   last_rdy = -1;
  bit   prev_sv = 0;
  bit   chk_gap = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nasrt++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [31:0] d);
    exp_t e;
    e.idx  = i;
    e.data = d;
    sbq.push_back(e);
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_sv"}, {31'd0, s_valid}, 0);
    chk({tag, "_sa"}, s_addr, 0);
    chk({tag, "_sd"}, s_wdata, 0);
    chk({tag, "_ss"}, {28'd0, s_wstrb}, 0);
    chk({tag, "_rdy"}, {30'd0, m1_ready, m0_ready}, 0);
    chk({tag, "_rd"}, m0_rdata | m1_rdata, 0);
    chk({tag, "_err"}, {31'd0, timeout_err}, 0);
  endtask

  // One clock: observe outputs, scoreboard, then drive masters/slave.
  task automatic step();
    exp_t e;
    @(posedge CLK);
    #1;
    cyc_n++;
    if (s_valid && !prev_sv && chk_gap && last_rdy >= 0)
      chk("gap", cyc_n - last_rdy, 2);
    prev_sv = s_valid;
    chk("both_rdy", {31'd0, m0_ready & m1_ready}, 0);
    if (m0_ready || m1_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_empty", {30'd0, m1_ready, m0_ready}, 0);
      end else begin
        e = sbq.pop_front();
        chk("rdy_idx", {31'd0, m1_ready}, e.idx);
        chk("rdata", m1_ready ? m1_rdata : m0_rdata, e.data);
        chk("oth_rdata", m1_ready ? m0_rdata : m1_rdata, 0);
      end
      last_rdy = cyc_n;
    end else begin
      chk("idle_rdata", m0_rdata | m1_rdata, 0);
    end
    if (m0_ready) m0_valid = 0;
    else if (!m0_valid && m0_left > 0) begin
      m0_valid = 1;
      m0_left--;
    end
    if (m1_ready) m1_valid = 0;
    else if (!m1_valid && m1_left > 0) begin
      m1_valid = 1;
      m1_left--;
    end
    if (slv_en) begin
      s_ready = 0;
      if (s_valid) begin
        if (sv_age == slv_lat) begin
          s_ready = 1;
          s_rdata = s_addr[8] ? 32'hB1 : 32'hA0;
        end
        sv_age++;
      end else begin
        sv_age = 0;
      end
    end
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (sbq.size() != 0 && n < maxc) begin
      step();
      n++;
    end
    chk("drain", sbq.size(), 0);
    step();
    step();
  endtask

  initial begin
    resetn = 0;
    m0_valid = 0; m1_valid = 0;
    m0_wstrb = 0; m1_wstrb = 0;
    m0_addr = 32'h0300_0000; m1_addr = 32'h0300_0100;
    m0_wdata = 0; m1_wdata = 0;
    s_ready = 0; s_rdata = 0; err_clr = 0;

    // Reset state
    @(posedge CLK);
    #1;
    chk_zero_outs("rst");
    resetn = 1;

    // Both masters read continuously: 0,1,0,1 with one dead cycle
    slv_en = 1; slv_lat = 1;
    push(0, 32'hA0); push(1, 32'hB1);
    push(0, 32'hA0); push(1, 32'hB1);
    m0_left = 2; m1_left = 2;
    chk_gap = 1; last_rdy = -1;
    drain(60);
    chk_gap = 0;

    // Single m0 write, ready at cycle 3
    m0_wstrb = 4'hF; m0_wdata = 32'h1;
    push(0, 32'hA0);
    m0_left = 1;
    step();
    c0 = cyc_n;
    step();
    chk("w_sv", {31'd0, s_valid}, 1);
    chk("w_sa", s_addr, 32'h0300_0000);
    chk("w_sd", s_wdata, 32'h1);
    chk("w_ss", {28'd0, s_wstrb}, 32'hF);
    step();
    chk("w_hold", s_addr, 32'h0300_0000);
    step();
    chk("w_rdy", {30'd0, m1_ready, m0_ready}, 1);
    chk("w_lat", cyc_n - c0, 3);
    step();
    chk("w_once", {31'd0, m0_ready}, 0);
    m0_wstrb = 0; m0_wdata = 0;
    drain(10);

    // m1 alone, m0 joins mid-BUSY and is served next
    slv_lat = 3;
    m1_left = 1;
    step();
    step();
    chk("j_sa", s_addr, 32'h0300_0100);
    m0_left = 1;
    push(1, 32'hB1); push(0, 32'hA0);
    drain(40);
    slv_lat = 1;

    // Stray s_ready in IDLE and DONE
    slv_en = 0;
    s_ready = 1; s_rdata = 32'h55;
    step();
    step();
    chk("stray_idle", {31'd0, s_valid}, 0);
    s_ready = 0;
    m0_left = 1;
    step();
    step();
    chk("d_sv", {31'd0, s_valid}, 1);
    push(0, 32'h55);
    s_ready = 1;
    step();
    chk("d_done", {31'd0, s_valid}, 0);
    step();
    chk("d_idle", {31'd0, s_valid}, 0);
    step();
    chk("d_idle2", {31'd0, s_valid}, 0);
    s_ready = 0;
    chk("d_sb", sbq.size(), 0);

`ifdef IOMEM_ARB_TIMEOUT_EN
    // Dead slave: forced completion with error data
    push(0, 32'hFFFF_FFFF);
    m0_left = 1;
    step();
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("wd_wait", {31'd0, m0_ready}, 0);
    end
    step();
    chk("wd_rdy", {31'd0, m0_ready}, 1);
    chk("wd_err", {31'd0, timeout_err}, 1);
    step();
    step();
    chk("wd_sticky", {31'd0, timeout_err}, 1);
    err_clr = 1;
    step();
    err_clr = 0;
    chk("wd_clr", {31'd0, timeout_err}, 0);

    // s_ready in the last BUSY cycle wins over the watchdog
    push(0, 32'hA0);
    m0_left = 1;
    step();
    for (int i = 1; i <= 8; i++) step();
    s_ready = 1; s_rdata = 32'hA0;
    step();
    s_ready = 0;
    chk("wd_late_rdy", {31'd0, m0_ready}, 1);
    chk("wd_late_err", {31'd0, timeout_err}, 0);
    step();
`else
    // No watchdog: BUSY waits for the slave indefinitely
    m0_left = 1;
    err_clr = 1;
    step();
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("nowd_wait", {31'd0, m0_ready}, 0);
    end
    chk("nowd_sv", {31'd0, s_valid}, 1);
    chk("nowd_err", {31'd0, timeout_err}, 0);
    err_clr = 0;
    push(0, 32'h1234_5678);
    s_ready = 1; s_rdata = 32'h1234_5678;
    step();
    s_ready = 0;
    chk("nowd_rdy", {31'd0, m0_ready}, 1);
    step();
`endif

    // Async reset mid-BUSY, then tie goes to m0
    m0_left = 1;
    step();
    step();
    chk("r_busy", {31'd0, s_valid}, 1);
    #2;
    resetn = 0;
    #1;
    chk_zero_outs("arst");
    m0_valid = 0; m1_valid = 0;
    m0_left = 0; m1_left = 0;
    sbq.delete();
    @(posedge CLK);
    #1;
    resetn = 1;
    prev_sv = 0;
    slv_en = 1;
    push(0, 32'hA0); push(1, 32'hB1);
    m0_left = 1; m1_left = 1;
    drain(40);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nasrt, nfail);
    $finish;
  end

endmodule
